// File: rtl/jtgng_char_pkg.sv
// Shared definitions for the character tile RAM CPU interface:
// FSM state encoding, default video slot and slot detection helper.
package jtgng_char_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } char_st_t;

  localparam logic [2:0] VSLOT_DEF = 3'd7;
  localparam int         TILE_AW   = 10;

  function automatic logic slot_hit(input logic cen, input logic [2:0] h, input logic [2:0] slot);
    return cen && (h == slot);
  endfunction

endpackage

// File: rtl/jtgng_ram.sv
// Single-port synchronous RAM; read data appears one enabled clock after the address.
module jtgng_ram
  import jtgng_char_pkg::*;
#(
  parameter int aw = TILE_AW,
  parameter int dw = 8
) (
  input  logic          clk,
  input  logic          i_cen,
  input  logic [aw-1:0] i_addr,
  input  logic [dw-1:0] i_data,
  input  logic          i_we,
  output logic [dw-1:0] o_q
);

  logic [dw-1:0] r_mem [0:(1<<aw)-1];

  // q only moves on enabled cycles so it survives until the next cen capture
  always_ff @(posedge clk) begin
    if (i_cen) begin
      if (i_we) begin
        r_mem[i_addr] <= i_data;
      end
      o_q <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/jtgng_char_cpuif.sv
// Character tile RAM (code + attribute banks) shared between the CPU and the
// video fetch; the video owns the RAM for one cen6 cycle when H hits VSLOT.
module jtgng_char_cpuif
  import jtgng_char_pkg::*;
#(
  parameter logic [2:0] VSLOT = VSLOT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic        char_cs,
  input  logic        RnW,
  input  logic [10:0] cpu_AB,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  char_dout,
  output logic        ch_mrdy,
  input  logic [2:0]  H,
  input  logic [9:0]  scan_addr,
  output logic [7:0]  char_code,
  output logic [7:0]  char_attr
);

  char_st_t    r_state;
  char_st_t    w_state_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_vid_pend;
  logic        w_issue_raw;
  logic        w_issue;
  logic        w_dout_ld;
  logic        w_vslot;
  logic        w_vid_own;
  logic        w_we_code;
  logic        w_we_attr;
  logic [9:0]  w_ram_addr;
  logic [7:0]  w_q_code;
  logic [7:0]  w_q_attr;

  assign w_vslot    = slot_hit(cen6, H, VSLOT);
  // The cycle after a video slot always belongs to the CPU
  assign w_vid_own  = w_vslot && (r_state != ST_WAIT);
  assign w_issue    = w_issue_raw && !rst;
  assign w_ram_addr = w_vid_own ? scan_addr : cpu_AB[9:0];
  assign w_we_code  = w_issue && !RnW && !cpu_AB[10];
  assign w_we_attr  = w_issue && !RnW &&  cpu_AB[10];
  assign ch_mrdy    = !(char_cs && !r_done);

  jtgng_ram #(.aw(10), .dw(8)) u_code (
    .clk    (clk),
    .i_cen  (cen6),
    .i_addr (w_ram_addr),
    .i_data (cpu_dout),
    .i_we   (w_we_code),
    .o_q    (w_q_code)
  );

  jtgng_ram #(.aw(10), .dw(8)) u_attr (
    .clk    (clk),
    .i_cen  (cen6),
    .i_addr (w_ram_addr),
    .i_data (cpu_dout),
    .i_we   (w_we_attr),
    .o_q    (w_q_attr)
  );

  // CPU access sequencing: slot arbitration, completion and release
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_done;
    w_issue_raw = 1'b0;
    w_dout_ld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_done_nxt = 1'b0;
        if (cen6 && char_cs) begin
          if (w_vslot) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_issue_raw = 1'b1;
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!char_cs) begin
          w_state_nxt = ST_IDLE;
        end else if (cen6) begin
          w_issue_raw = 1'b1;
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DATA: begin
        if (!char_cs) begin
          w_state_nxt = ST_IDLE;
        end else if (cen6) begin
          w_done_nxt  = 1'b1;
          w_dout_ld   = RnW;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_HOLD: begin
        if (!char_cs) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_done_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and done flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Registered read data for the CPU and tile bytes for the video pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_dout  <= 8'd0;
      char_code  <= 8'd0;
      char_attr  <= 8'd0;
      r_vid_pend <= 1'b0;
    end else begin
      if (w_dout_ld) begin
        char_dout <= cpu_AB[10] ? w_q_attr : w_q_code;
      end
      if (cen6) begin
        if (r_vid_pend) begin
          char_code <= w_q_code;
          char_attr <= w_q_attr;
        end
        r_vid_pend <= w_vid_own;
      end
    end
  end

endmodule

// File: tb/tb_jtgng_char_cpuif.sv
// Randomized bench for jtgng_char_cpuif against a behavioural model of the
// tile RAM, the CPU access latency rules and the video fetch.
module tb_jtgng_char_cpuif;

  localparam logic [2:0] VSLOT = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen6;
  logic        char_cs;
  logic        RnW;
  logic [10:0] cpu_AB;
  logic [7:0]  cpu_dout;
  logic [7:0]  char_dout;
  logic        ch_mrdy;
  logic [2:0]  H;
  logic [9:0]  scan_addr;
  logic [7:0]  char_code;
  logic [7:0]  char_attr;

  jtgng_char_cpuif dut (
    .clk       (clk),
    .rst       (rst),
    .cen6      (cen6),
    .char_cs   (char_cs),
    .RnW       (RnW),
    .cpu_AB    (cpu_AB),
    .cpu_dout  (cpu_dout),
    .char_dout (char_dout),
    .ch_mrdy   (ch_mrdy),
    .H         (H),
    .scan_addr (scan_addr),
    .char_code (char_code),
    .char_attr (char_attr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int n_slots  = 0;

  // behavioural model state
  logic [7:0] m_code [0:1023];
  logic [7:0] m_attr [0:1023];
  bit         m_cv   [0:1023];
  bit         m_av   [0:1023];
  logic [7:0] exp_dout = 8'd0;
  logic [7:0] exp_code = 8'd0;
  logic [7:0] exp_attr = 8'd0;
  bit         exp_vvalid = 1'b1;
  bit         vpend = 1'b0;
  bit         vval  = 1'b0;
  logic [7:0] vcode = 8'd0;
  logic [7:0] vattr = 8'd0;
  bit         scan_fix_en = 1'b0;
  logic [9:0] scan_fix_val = 10'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // clock enable, pixel counter and scan address generator
  initial begin
    cen6 = 1'b0; H = 3'd0; scan_addr = 10'd0;
    forever begin
      @(posedge clk); #1;
      if (cen6) begin
        H = H + 3'd1;
        scan_addr = scan_fix_en ? scan_fix_val : 10'($urandom_range(0, 63));
        cen6 = 1'b0;
      end else begin
        cen6 = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // video model: slot latches the tile bytes, next cen6 presents them
  always @(posedge clk) begin
    if (!rst && cen6) begin
      if (vpend) begin
        exp_code   = vcode;
        exp_attr   = vattr;
        exp_vvalid = vval;
      end
      vpend = (H == VSLOT);
      if (H == VSLOT) begin
        vcode = m_code[scan_addr];
        vattr = m_attr[scan_addr];
        vval  = m_cv[scan_addr] && m_av[scan_addr];
        n_slots++;
      end
    end
  end

  always @(negedge clk) begin
    if (dut.w_we_code || dut.w_we_attr) wr_cnt++;
  end

  // per-cycle output comparison
  always @(negedge clk) begin
    chk("char_dout", char_dout, exp_dout);
    if (exp_vvalid) begin
      chk("char_code", char_code, exp_code);
      chk("char_attr", char_attr, exp_attr);
    end
  end

  task automatic do_access(input logic rnw, input logic [10:0] ab, input logic [7:0] wd,
                           input int align_h, output int lat);
    int n, iss, w0;
    bit ok;
    w0 = wr_cnt;
    if (align_h < 0) begin
      @(posedge clk); #2;
    end else begin
      ok = 1'b0;
      for (int k = 0; k < 300 && !ok; k++) begin
        @(posedge clk); #2;
        if (cen6 && H == 3'(align_h)) ok = 1'b1;
      end
      if (!ok) chk("align_timeout", 32'd0, 32'd1);
    end
    char_cs = 1'b1; RnW = rnw; cpu_AB = ab; cpu_dout = wd;
    n = 0; lat = 0; iss = 0; ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (lat != 0 && n >= lat) begin
        chk("mrdy_release", {31'd0, ch_mrdy}, 32'd1);
        ok = 1'b1;
      end else begin
        chk("mrdy_stall", {31'd0, ch_mrdy}, 32'd0);
        @(posedge clk);
        if (cen6) begin
          n++;
          if (n == 1) begin
            lat = (H == VSLOT) ? 3 : 2;
            iss = lat - 1;
          end
          if (!rnw && n == iss) begin
            if (ab[10]) begin m_attr[ab[9:0]] = wd; m_av[ab[9:0]] = 1'b1; end
            else        begin m_code[ab[9:0]] = wd; m_cv[ab[9:0]] = 1'b1; end
          end
          if (rnw && n == lat) exp_dout = ab[10] ? m_attr[ab[9:0]] : m_code[ab[9:0]];
        end
      end
    end
    if (!ok) chk("access_timeout", 32'd0, 32'd1);
    char_cs = 1'b0; RnW = 1'b1;
    chk("write_pulses", 32'(wr_cnt - w0), rnw ? 32'd0 : 32'd1);
  endtask

  int lat, w0, gap, s0;
  logic [7:0] old1;
  bit ok;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; char_cs = 1'b0; RnW = 1'b1; cpu_AB = 11'd0; cpu_dout = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dout", char_dout, 32'd0);
    chk("reset_code", char_code, 32'd0);
    chk("reset_attr", char_attr, 32'd0);
    chk("reset_mrdy", {31'd0, ch_mrdy}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 64; i++) begin
      do_access(1'b0, {1'b0, 10'(i)}, 8'($urandom), -1, lat);
      do_access(1'b0, {1'b1, 10'(i)}, 8'($urandom), -1, lat);
    end

    // read without collision
    do_access(1'b0, 11'h005, 8'h3C, 2, lat);
    do_access(1'b1, 11'h005, 8'h00, 2, lat);
    chk("read_lat", lat, 32'd2);
    chk("read_data", char_dout, 32'h3C);

    // write landing in a video slot
    do_access(1'b0, 11'h412, 8'h7E, 7, lat);
    chk("slot_write_lat", lat, 32'd3);
    do_access(1'b1, 11'h412, 8'h00, 3, lat);
    chk("slot_write_rd", char_dout, 32'h7E);

    // video fetch of tile 0x012
    scan_fix_val = 10'h012; scan_fix_en = 1'b1;
    s0 = n_slots; ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (n_slots >= s0 + 2) ok = 1'b1;
    end
    if (!ok) chk("slot_timeout", 32'd0, 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      if (cen6) ok = 1'b1;
    end
    @(negedge clk);
    chk("video_attr", char_attr, 32'h7E);
    chk("video_code", char_code, m_code[10'h012]);
    scan_fix_en = 1'b0;

    // back-to-back writes
    w0 = wr_cnt;
    do_access(1'b0, 11'h000, 8'h11, -1, lat);
    do_access(1'b0, 11'h000, 8'h22, -1, lat);
    chk("b2b_pulses", 32'(wr_cnt - w0), 32'd2);
    do_access(1'b1, 11'h000, 8'h00, -1, lat);
    chk("b2b_data", char_dout, 32'h22);

    // reset while a write waits behind a video slot
    old1 = m_code[10'h001];
    w0 = wr_cnt; ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #2;
      if (cen6 && H == VSLOT) ok = 1'b1;
    end
    if (!ok) chk("align_timeout", 32'd0, 32'd1);
    char_cs = 1'b1; RnW = 1'b0; cpu_AB = 11'h001; cpu_dout = 8'h55;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_dout = 8'd0; exp_code = 8'd0; exp_attr = 8'd0; exp_vvalid = 1'b1; vpend = 1'b0;
    @(negedge clk);
    chk("rst_dout", char_dout, 32'd0);
    chk("rst_code", char_code, 32'd0);
    chk("rst_attr", char_attr, 32'd0);
    char_cs = 1'b0; RnW = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_no_write", 32'(wr_cnt - w0), 32'd0);
    do_access(1'b1, 11'h001, 8'h00, -1, lat);
    chk("rst_mem_kept", char_dout, old1);

    // idle bus
    w0 = wr_cnt;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("idle_mrdy", {31'd0, ch_mrdy}, 32'd1);
    end
    chk("idle_no_write", 32'(wr_cnt - w0), 32'd0);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      do_access(1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 10'($urandom_range(0, 63))},
                8'($urandom), ($urandom_range(0, 3) == 0) ? 7 : -1, lat);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("gap_mrdy", {31'd0, ch_mrdy}, 32'd1);
      end
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
